// File: rtl/mps_op_on_sequencer.sv
// OP-ON responder: steps the contactor power-up sequence and verifies MC feedback and precharge.
// Optional build macro MPS_OP_ON_DCLINK_CHECK_EN ends precharge on a DC-link threshold instead of a fixed time.
module mps_op_on_sequencer #(
  parameter int unsigned T_MC_CNT     = 1000,
  parameter int unsigned T_CHARGE_CNT = 500000,
  parameter logic [15:0] DC_LINK_TH   = 16'h4000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_op_on_flag,
  input  logic        i_intl_flag,
  input  logic [2:0]  i_mc_fb,
  input  logic [15:0] i_dc_link,
  output logic [3:0]  o_op_on_fsm,
  output logic        o_busy,
  output logic [3:0]  o_fail_step
);

  typedef enum logic [3:0] {
    S_IDLE          = 4'd0,
    S_DISCH_CMD     = 4'd1,
    S_DISCH_WAIT    = 4'd2,
    S_SLOW_CMD      = 4'd5,
    S_SLOW_WAIT     = 4'd6,
    S_CHARGE        = 4'd7,
    S_MAIN_CMD      = 4'd9,
    S_MAIN_WAIT     = 4'd10,
    S_SLOW_OFF_CMD  = 4'd11,
    S_SLOW_OFF_WAIT = 4'd12,
    S_DONE          = 4'd14,
    S_FAIL          = 4'd15
  } state_t;

  localparam logic [31:0] MC_LAST = 32'(T_MC_CNT - 1);
  localparam logic [31:0] CH_LAST = 32'(T_CHARGE_CNT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [3:0]  r_fail_step;
  logic [3:0]  w_fail_step_nxt;
  logic        r_busy;
  logic        w_mc_tc;
  logic        w_ch_tc;

  assign w_mc_tc = (r_cnt == MC_LAST);
  assign w_ch_tc = (r_cnt == CH_LAST);

`ifndef MPS_OP_ON_DCLINK_CHECK_EN
  logic w_unused_dc;
  assign w_unused_dc = ^i_dc_link;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_fail_step_nxt = r_fail_step;
    case (r_state)
      S_IDLE: begin
        if (i_op_on_flag && !i_intl_flag) begin
          w_state_nxt     = S_DISCH_CMD;
          w_fail_step_nxt = 4'd0;
        end
      end
      S_DISCH_CMD:    w_state_nxt = S_DISCH_WAIT;
      S_SLOW_CMD:     w_state_nxt = S_SLOW_WAIT;
      S_MAIN_CMD:     w_state_nxt = S_MAIN_WAIT;
      S_SLOW_OFF_CMD: w_state_nxt = S_SLOW_OFF_WAIT;
      S_DISCH_WAIT: begin
        if (w_mc_tc) begin
          if (i_mc_fb == 3'b100) w_state_nxt = S_SLOW_CMD;
          else begin
            w_state_nxt     = S_FAIL;
            w_fail_step_nxt = 4'd2;
          end
        end
      end
      S_SLOW_WAIT: begin
        if (w_mc_tc) begin
          if (i_mc_fb == 3'b110) w_state_nxt = S_CHARGE;
          else begin
            w_state_nxt     = S_FAIL;
            w_fail_step_nxt = 4'd6;
          end
        end
      end
      S_CHARGE: begin
`ifdef MPS_OP_ON_DCLINK_CHECK_EN
        if (i_dc_link >= DC_LINK_TH) w_state_nxt = S_MAIN_CMD;
        else if (w_ch_tc) begin
          w_state_nxt     = S_FAIL;
          w_fail_step_nxt = 4'd7;
        end
`else
        if (w_ch_tc) w_state_nxt = S_MAIN_CMD;
`endif
      end
      S_MAIN_WAIT: begin
        if (w_mc_tc) begin
          if (i_mc_fb == 3'b111) w_state_nxt = S_SLOW_OFF_CMD;
          else begin
            w_state_nxt     = S_FAIL;
            w_fail_step_nxt = 4'd10;
          end
        end
      end
      S_SLOW_OFF_WAIT: begin
        if (w_mc_tc) begin
          if (i_mc_fb == 3'b101) w_state_nxt = S_DONE;
          else begin
            w_state_nxt     = S_FAIL;
            w_fail_step_nxt = 4'd12;
          end
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      S_FAIL:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    // Interlock overrides every transition and leaves the recorded cause alone.
    if ((r_state != S_IDLE) && i_intl_flag) begin
      w_state_nxt     = S_IDLE;
      w_fail_step_nxt = r_fail_step;
    end
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_state_nxt != r_state) w_cnt_nxt = 32'd0;
    else if (r_cnt != 32'hFFFF_FFFF) w_cnt_nxt = r_cnt + 32'd1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 32'd0;
      r_fail_step <= 4'd0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_fail_step <= w_fail_step_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign o_op_on_fsm = r_state;
  assign o_busy      = r_busy;
  assign o_fail_step = r_fail_step;

endmodule

// File: tb/tb_mps_op_on_sequencer.sv
// Bench for mps_op_on_sequencer: table-driven step model checked every cycle plus literal pins.
module tb_mps_op_on_sequencer;

  localparam int TMC = 4;
  localparam int TCH = 10;
  localparam logic [15:0] TH = 16'h4000;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_op_on_flag = 1'b0;
  logic        i_intl_flag = 1'b0;
  logic [2:0]  i_mc_fb = 3'b000;
  logic [15:0] i_dc_link = 16'h0000;
  logic [3:0]  o_op_on_fsm;
  logic        o_busy;
  logic [3:0]  o_fail_step;

  mps_op_on_sequencer #(.T_MC_CNT(TMC), .T_CHARGE_CNT(TCH), .DC_LINK_TH(TH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_op_on_flag(i_op_on_flag), .i_intl_flag(i_intl_flag),
    .i_mc_fb(i_mc_fb), .i_dc_link(i_dc_link), .o_op_on_fsm(o_op_on_fsm), .o_busy(o_busy),
    .o_fail_step(o_fail_step)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Power-up recipe: step code, kind (0 command, 1 feedback wait, 2 precharge, 3 done), feedback.
  int         m_code[10] = '{1, 2, 5, 6, 7, 9, 10, 11, 12, 14};
  int         m_kind[10] = '{0, 1, 0, 1, 2, 0, 1, 0, 1, 3};
  logic [2:0] m_fbx[10]  = '{3'b000, 3'b100, 3'b000, 3'b110, 3'b000,
                             3'b000, 3'b111, 3'b000, 3'b101, 3'b000};

  bit   m_valid = 0;
  bit   m_busy  = 0;
  bit   m_fail  = 0;
  int   m_idx   = 0;
  int   m_age   = 0;
  int   m_fs    = 0;
  bit   fb_auto = 0;

  always @(posedge i_clk) begin
    if (!i_rst) begin
      m_valid = 1; m_busy = 0; m_fail = 0; m_idx = 0; m_age = 0; m_fs = 0;
    end else if (!m_busy) begin
      if (i_op_on_flag && !i_intl_flag) begin
        m_busy = 1; m_fail = 0; m_idx = 0; m_age = 0; m_fs = 0;
      end
    end else if (i_intl_flag || m_fail) begin
      m_busy = 0; m_fail = 0;
    end else begin
      case (m_kind[m_idx])
        0: begin m_idx++; m_age = 0; end
        1: begin
          if (m_age == TMC - 1) begin
            if (i_mc_fb == m_fbx[m_idx]) begin m_idx++; m_age = 0; end
            else begin m_fail = 1; m_fs = m_code[m_idx]; end
          end else m_age++;
        end
        2: begin
`ifdef MPS_OP_ON_DCLINK_CHECK_EN
          if (i_dc_link >= TH) begin m_idx++; m_age = 0; end
          else if (m_age == TCH - 1) begin m_fail = 1; m_fs = 7; end
          else m_age++;
`else
          if (m_age == TCH - 1) begin m_idx++; m_age = 0; end
          else m_age++;
`endif
        end
        default: m_busy = 0;
      endcase
    end
  end

  always @(negedge i_clk) begin
    if (m_valid) begin
      chk("code", 32'(o_op_on_fsm), m_busy ? (m_fail ? 32'd15 : 32'(m_code[m_idx])) : 32'd0);
      chk("busy", 32'(o_busy), 32'(m_busy));
      chk("fail_step", 32'(o_fail_step), 32'(m_fs));
    end
    if (fb_auto) i_mc_fb = (m_busy && !m_fail) ? m_fbx[m_idx] : 3'b000;
  end

  task automatic start_pulse;
    i_op_on_flag = 1'b1;
    @(negedge i_clk);
    i_op_on_flag = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 300 && !(n > 0 && !o_busy); k++) begin
      if (o_busy) n++;
      @(negedge i_clk);
    end
    chk("idle_reached", 32'(o_busy), 32'd0);
  endtask

  int n;
  int k;

  initial begin
    // 1: reset
    repeat (3) @(negedge i_clk);
    chk("rst_code", 32'(o_op_on_fsm), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_fail_step", 32'(o_fail_step), 32'd0);
    i_rst = 1'b1;
    @(negedge i_clk);

    // 2: nominal sequence
    fb_auto = 1;
`ifdef MPS_OP_ON_DCLINK_CHECK_EN
    i_dc_link = 16'h4000;
`else
    i_dc_link = 16'h0000;
`endif
    start_pulse();
    chk("first_code", 32'(o_op_on_fsm), 32'd1);
    count_busy(n);
`ifdef MPS_OP_ON_DCLINK_CHECK_EN
    chk("nominal_len", 32'(n), 32'd22);
`else
    chk("nominal_len", 32'(n), 32'd31);
`endif
    chk("nominal_fs", 32'(o_fail_step), 32'd0);

    // 3: discharge feedback missing
    fb_auto = 0; i_mc_fb = 3'b000;
    start_pulse();
    repeat (5) @(negedge i_clk);
    chk("disch_fail_code", 32'(o_op_on_fsm), 32'd15);
    @(negedge i_clk);
    chk("disch_fail_idle", 32'(o_op_on_fsm), 32'd0);
    chk("disch_fail_fs", 32'(o_fail_step), 32'd2);

    // 4: precharge
    fb_auto = 1; i_dc_link = 16'h3FFF;
    start_pulse();
    repeat (20) @(negedge i_clk);
`ifdef MPS_OP_ON_DCLINK_CHECK_EN
    chk("charge_timeout_code", 32'(o_op_on_fsm), 32'd15);
    @(negedge i_clk);
    chk("charge_timeout_fs", 32'(o_fail_step), 32'd7);
    start_pulse();
    repeat (12) @(negedge i_clk);
    chk("charge_third", 32'(o_op_on_fsm), 32'd7);
    i_dc_link = 16'h4000;
    @(negedge i_clk);
    chk("charge_exit", 32'(o_op_on_fsm), 32'd9);
`else
    chk("charge_fixed_exit", 32'(o_op_on_fsm), 32'd9);
`endif
    count_busy(n);
    chk("charge_fs", 32'(o_fail_step), 32'd0);

    // 5: interlock during precharge, then start blocked by interlock
    i_dc_link = 16'h0000;
    start_pulse();
    repeat (12) @(negedge i_clk);
    chk("intl_pre", 32'(o_op_on_fsm), 32'd7);
    i_intl_flag = 1'b1;
    @(negedge i_clk);
    chk("intl_abort", 32'(o_op_on_fsm), 32'd0);
    chk("intl_fs", 32'(o_fail_step), 32'd0);
    i_op_on_flag = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("intl_block", 32'(o_op_on_fsm), 32'd0);
    i_op_on_flag = 1'b0; i_intl_flag = 1'b0;
    @(negedge i_clk);

    // 6: start held high across the sequence
    i_dc_link = 16'hFFFF;
    i_op_on_flag = 1'b1;
    @(negedge i_clk);
    chk("hold_start", 32'(o_op_on_fsm), 32'd1);
    for (k = 0; k < 100 && o_op_on_fsm != 4'd14; k++) @(negedge i_clk);
    chk("hold_done", 32'(o_op_on_fsm), 32'd14);
    @(negedge i_clk);
    chk("hold_idle", 32'(o_op_on_fsm), 32'd0);
    @(negedge i_clk);
    chk("hold_restart", 32'(o_op_on_fsm), 32'd1);
    i_op_on_flag = 1'b0;

    // reset mid-sequence
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("midrst_code", 32'(o_op_on_fsm), 32'd0);
    chk("midrst_busy", 32'(o_busy), 32'd0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
